// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN          = 2'd0,
    FROZEN       = 2'd1,
    FROZEN_REDIR = 2'd2
  } hz_state_e;

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [4:0] REG_X0  = 5'd0;

  // True when a source operand that is actually read matches a destination.
  function automatic logic src_hit(input logic       rs_valid,
                                   input logic [4:0] rs_addr,
                                   input logic [4:0] rd_addr);
    return rs_valid && (rs_addr == rd_addr);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline and the hazard controller; master = pipeline side,
// slave = controller side.
interface hazard_ctrl_if #(
  parameter int XLEN = 32
);
  logic            id_valid;
  logic [4:0]      id_rs1_addr;
  logic [4:0]      id_rs2_addr;
  logic            id_rs1_valid;
  logic            id_rs2_valid;
  logic            ex_valid;
  logic [4:0]      ex_rd_addr;
  logic            ex_rd_valid;
  logic            ex_is_load;
  logic            icache_stall;
  logic            dcache_stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;

  logic            pc_enable;
  logic            if_id_enable;
  logic            id_ex_enable;
  logic            ex_mem_enable;
  logic            id_ex_bubble;
  logic            if_id_flush;
  logic            id_ex_flush;
  logic            pc_redirect;
  logic [XLEN-1:0] pc_redirect_target;
  logic            cache_stall_out;

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_valid, id_rs2_valid,
           ex_valid, ex_rd_addr, ex_rd_valid, ex_is_load,
           icache_stall, dcache_stall, redirect, redirect_target,
    input  pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, id_ex_bubble,
           if_id_flush, id_ex_flush, pc_redirect, pc_redirect_target, cache_stall_out
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_valid, id_rs2_valid,
           ex_valid, ex_rd_addr, ex_rd_valid, ex_is_load,
           icache_stall, dcache_stall, redirect, redirect_target,
    output pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, id_ex_bubble,
           if_id_flush, id_ex_flush, pc_redirect, pc_redirect_target, cache_stall_out
  );

endinterface

// File: rtl/hazard_ctrl_perf_counters.sv
// Saturating event counters for stall cycles, load-use bubbles and redirect flushes.
module hazard_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_evt,
  input  logic             bubble_evt,
  input  logic             flush_evt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubbles,
  output logic [CNT_W-1:0] flushes
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      bubbles      <= '0;
      flushes      <= '0;
    end else begin
      if (stall_evt && stall_cycles != CNT_MAX) stall_cycles <= stall_cycles + CNT_ONE;
      if (bubble_evt && bubbles != CNT_MAX)     bubbles      <= bubbles + CNT_ONE;
      if (flush_evt && flushes != CNT_MAX)      flushes      <= flushes + CNT_ONE;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freeze on cache stall, flush on redirect, bubble on load-use.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
//
// state        | meaning
// RUN          | pipeline flowing; redirects and load-use handled immediately
// FROZEN       | cache stall seen last cycle, no redirect held
// FROZEN_REDIR | cache stall seen with a redirect held in pend_q until release
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_if.slave     bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cycles,
  output logic [CNT_W-1:0] perf_bubbles,
  output logic [CNT_W-1:0] perf_flushes
`endif
);

  hz_state_e       state_q, state_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            cstall;
  logic            load_use;
  logic            take_redir;

  assign cstall = bus.icache_stall | bus.dcache_stall;

  assign load_use = bus.ex_valid && bus.ex_is_load && bus.ex_rd_valid &&
                    (bus.ex_rd_addr != REG_X0) && bus.id_valid &&
                    (src_hit(bus.id_rs1_valid, bus.id_rs1_addr, bus.ex_rd_addr) ||
                     src_hit(bus.id_rs2_valid, bus.id_rs2_addr, bus.ex_rd_addr));

  assign take_redir = !cstall && (bus.redirect || (state_q == FROZEN_REDIR));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Only the first redirect seen during a freeze is kept; later ones are dropped.
  always_comb begin
    state_d = RUN;
    pend_d  = '0;
    if (cstall) begin
      if (state_q == FROZEN_REDIR) begin
        state_d = FROZEN_REDIR;
        pend_d  = pend_q;
      end else if (bus.redirect) begin
        state_d = FROZEN_REDIR;
        pend_d  = bus.redirect_target;
      end else begin
        state_d = FROZEN;
      end
    end
  end

  always_comb begin
    bus.pc_enable          = 1'b0;
    bus.if_id_enable       = 1'b0;
    bus.id_ex_enable       = 1'b0;
    bus.ex_mem_enable      = 1'b0;
    bus.id_ex_bubble       = 1'b0;
    bus.if_id_flush        = 1'b0;
    bus.id_ex_flush        = 1'b0;
    bus.pc_redirect        = 1'b0;
    bus.pc_redirect_target = '0;
    bus.cache_stall_out    = 1'b0;
    if (!rst) begin
      bus.cache_stall_out = cstall;
      if (cstall) begin
        bus.pc_enable = 1'b0;
      end else if (take_redir) begin
        bus.pc_enable          = 1'b1;
        bus.if_id_enable       = 1'b1;
        bus.id_ex_enable       = 1'b1;
        bus.ex_mem_enable      = 1'b1;
        bus.if_id_flush        = 1'b1;
        bus.id_ex_flush        = 1'b1;
        bus.pc_redirect        = 1'b1;
        bus.pc_redirect_target = (state_q == FROZEN_REDIR) ? pend_q : bus.redirect_target;
      end else if (load_use) begin
        bus.id_ex_bubble  = 1'b1;
        bus.id_ex_enable  = 1'b1;
        bus.ex_mem_enable = 1'b1;
      end else begin
        bus.pc_enable     = 1'b1;
        bus.if_id_enable  = 1'b1;
        bus.id_ex_enable  = 1'b1;
        bus.ex_mem_enable = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk          (clk),
    .rst          (rst),
    .stall_evt    (bus.cache_stall_out),
    .bubble_evt   (bus.id_ex_bubble),
    .flush_evt    (bus.pc_redirect),
    .stall_cycles (perf_stall_cycles),
    .bubbles      (perf_bubbles),
    .flushes      (perf_flushes)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model.
module tb_hazard_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, bubble, if_id_flush, id_ex_flush, pc_redirect, cache_stall_out}
  localparam logic [8:0] V_ZERO   = 9'b0000_0000_0;
  localparam logic [8:0] V_NORMAL = 9'b1111_0000_0;
  localparam logic [8:0] V_FREEZE = 9'b0000_0000_1;
  localparam logic [8:0] V_REDIR  = 9'b1111_0111_0;
  localparam logic [8:0] V_LU     = 9'b0011_1000_0;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  hazard_ctrl_if #(.XLEN(XLEN)) bus ();

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] perf_stall_cycles, perf_bubbles, perf_flushes;
`endif

  hazard_ctrl #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_bubbles      (perf_bubbles),
    .perf_flushes      (perf_flushes)
`endif
  );

  logic [8:0] obs;
  assign obs = {bus.pc_enable, bus.if_id_enable, bus.id_ex_enable, bus.ex_mem_enable,
                bus.id_ex_bubble, bus.if_id_flush, bus.id_ex_flush, bus.pc_redirect,
                bus.cache_stall_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic clear_in();
    bus.id_valid        = 1'b0;
    bus.id_rs1_addr     = 5'd0;
    bus.id_rs2_addr     = 5'd0;
    bus.id_rs1_valid    = 1'b0;
    bus.id_rs2_valid    = 1'b0;
    bus.ex_valid        = 1'b0;
    bus.ex_rd_addr      = 5'd0;
    bus.ex_rd_valid     = 1'b0;
    bus.ex_is_load      = 1'b0;
    bus.icache_stall    = 1'b0;
    bus.dcache_stall    = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_target = '0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs2, input logic rs2_v);
    bus.ex_valid     = 1'b1;
    bus.ex_is_load   = 1'b1;
    bus.ex_rd_valid  = 1'b1;
    bus.ex_rd_addr   = rd;
    bus.id_valid     = 1'b1;
    bus.id_rs1_addr  = 5'd17;
    bus.id_rs1_valid = 1'b1;
    bus.id_rs2_addr  = rs2;
    bus.id_rs2_valid = rs2_v;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_in();
    set_load_use(5'd5, 5'd5, 1'b1);
    bus.dcache_stall    = 1'b1;
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (obs !== V_ZERO) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", obs, V_ZERO);
    end
    checks++;
    if (bus.pc_redirect_target !== 32'h0) begin
      errors++;
      $display("FAIL reset_target: got %h expected 0", bus.pc_redirect_target);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_in();
    #1;
    checks++;
    if (obs !== V_NORMAL) begin
      errors++;
      $display("FAIL reset_release_normal: got %b expected %b", obs, V_NORMAL);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if ({perf_stall_cycles, perf_bubbles, perf_flushes} !== '0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0",
               perf_stall_cycles, perf_bubbles, perf_flushes);
    end
`endif
  endtask

  task automatic test_load_use();
    @(negedge clk);
    clear_in();
    set_load_use(5'd5, 5'd5, 1'b1);
    #1;
    checks++;
    if (obs !== V_LU) begin
      errors++;
      $display("FAIL load_use_bubble: got %b expected %b", obs, V_LU);
    end
    // The bubble now sits in EX, so the hazard is gone.
    @(negedge clk);
    bus.ex_valid = 1'b0;
    #1;
    checks++;
    if (obs !== V_NORMAL) begin
      errors++;
      $display("FAIL load_use_after: got %b expected %b", obs, V_NORMAL);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (perf_bubbles !== 32'd1) begin
      errors++;
      $display("FAIL perf_bubbles: got %0d expected 1", perf_bubbles);
    end
`endif
    @(negedge clk);
    clear_in();
    set_load_use(5'd9, 5'd3, 1'b1);
    bus.id_rs1_addr = 5'd9;
    #1;
    checks++;
    if (obs !== V_LU) begin
      errors++;
      $display("FAIL load_use_rs1: got %b expected %b", obs, V_LU);
    end
  endtask

  task automatic test_load_use_neg();
    @(negedge clk);
    clear_in();
    set_load_use(5'd0, 5'd0, 1'b1);
    #1;
    checks++;
    if (obs !== V_NORMAL) begin
      errors++;
      $display("FAIL lu_x0: got %b expected %b", obs, V_NORMAL);
    end
    @(negedge clk);
    clear_in();
    set_load_use(5'd5, 5'd5, 1'b0);
    #1;
    checks++;
    if (obs !== V_NORMAL) begin
      errors++;
      $display("FAIL lu_rs2_not_read: got %b expected %b", obs, V_NORMAL);
    end
    @(negedge clk);
    clear_in();
    set_load_use(5'd5, 5'd5, 1'b1);
    bus.ex_is_load = 1'b0;
    #1;
    checks++;
    if (obs !== V_NORMAL) begin
      errors++;
      $display("FAIL lu_not_load: got %b expected %b", obs, V_NORMAL);
    end
  endtask

  task automatic test_redirect_run();
    @(negedge clk);
    clear_in();
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'h100;
    #1;
    checks++;
    if (obs !== V_REDIR) begin
      errors++;
      $display("FAIL redirect_run: got %b expected %b", obs, V_REDIR);
    end
    checks++;
    if (bus.pc_redirect_target !== 32'h100) begin
      errors++;
      $display("FAIL redirect_run_target: got %h expected 100", bus.pc_redirect_target);
    end
    @(negedge clk);
    bus.redirect = 1'b0;
    #1;
    checks++;
    if (obs !== V_NORMAL || bus.pc_redirect_target !== 32'h0) begin
      errors++;
      $display("FAIL redirect_run_after: got %b/%h expected %b/0", obs, bus.pc_redirect_target, V_NORMAL);
    end
  endtask

  task automatic test_freeze_redirect();
    logic [CNT_W-1:0] st0, fl0;
    st0 = '0;
    fl0 = '0;
`ifdef HAZARD_PERF_CNT_EN
    st0 = perf_stall_cycles;
    fl0 = perf_flushes;
`endif
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      clear_in();
      bus.dcache_stall    = 1'b1;
      bus.redirect        = (c == 1) || (c == 2);
      bus.redirect_target = (c == 1) ? 32'h200 : 32'h300;
      #1;
      checks++;
      if (obs !== V_FREEZE || bus.pc_redirect_target !== 32'h0) begin
        errors++;
        $display("FAIL freeze_cycle%0d: got %b/%h expected %b/0", c, obs, bus.pc_redirect_target, V_FREEZE);
      end
    end
    @(negedge clk);
    clear_in();
    bus.redirect_target = 32'h777;
    #1;
    checks++;
    if (obs !== V_REDIR) begin
      errors++;
      $display("FAIL freeze_release: got %b expected %b", obs, V_REDIR);
    end
    checks++;
    if (bus.pc_redirect_target !== 32'h200) begin
      errors++;
      $display("FAIL freeze_release_target: got %h expected 200", bus.pc_redirect_target);
    end
    @(negedge clk);
    #1;
    checks++;
    if (obs !== V_NORMAL) begin
      errors++;
      $display("FAIL freeze_after: got %b expected %b", obs, V_NORMAL);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (perf_stall_cycles - st0 !== 32'd4) begin
      errors++;
      $display("FAIL perf_stall_cycles: got delta %0d expected 4", perf_stall_cycles - st0);
    end
    checks++;
    if (perf_flushes - fl0 !== 32'd1) begin
      errors++;
      $display("FAIL perf_flushes: got delta %0d expected 1", perf_flushes - fl0);
    end
`endif
  endtask

  task automatic test_priority();
    @(negedge clk);
    clear_in();
    set_load_use(5'd5, 5'd5, 1'b1);
    bus.icache_stall    = 1'b1;
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'h400;
    #1;
    checks++;
    if (obs !== V_FREEZE) begin
      errors++;
      $display("FAIL priority_freeze: got %b expected %b", obs, V_FREEZE);
    end
    @(negedge clk);
    bus.icache_stall = 1'b0;
    bus.redirect     = 1'b0;
    #1;
    checks++;
    if (obs !== V_REDIR || bus.pc_redirect_target !== 32'h400) begin
      errors++;
      $display("FAIL priority_release: got %b/%h expected %b/400", obs, bus.pc_redirect_target, V_REDIR);
    end
    @(negedge clk);
    #1;
    checks++;
    if (obs !== V_LU) begin
      errors++;
      $display("FAIL priority_then_lu: got %b expected %b", obs, V_LU);
    end
  endtask

  task automatic test_same_cycle_release();
    @(negedge clk);
    clear_in();
    bus.icache_stall = 1'b1;
    #1;
    checks++;
    if (obs !== V_FREEZE) begin
      errors++;
      $display("FAIL plain_freeze: got %b expected %b", obs, V_FREEZE);
    end
    @(negedge clk);
    clear_in();
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'h500;
    #1;
    checks++;
    if (obs !== V_REDIR || bus.pc_redirect_target !== 32'h500) begin
      errors++;
      $display("FAIL same_cycle_redirect: got %b/%h expected %b/500", obs, bus.pc_redirect_target, V_REDIR);
    end
  endtask

  task automatic test_reset_mid_freeze();
    @(negedge clk);
    clear_in();
    bus.icache_stall    = 1'b1;
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'h600;
    #1;
    checks++;
    if (obs !== V_FREEZE) begin
      errors++;
      $display("FAIL rmf_freeze: got %b expected %b", obs, V_FREEZE);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== V_ZERO || bus.pc_redirect_target !== 32'h0) begin
      errors++;
      $display("FAIL rmf_in_reset: got %b/%h expected %b/0", obs, bus.pc_redirect_target, V_ZERO);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_in();
    #1;
    checks++;
    if (obs !== V_NORMAL || bus.pc_redirect_target !== 32'h0) begin
      errors++;
      $display("FAIL rmf_after_reset: got %b/%h expected %b/0", obs, bus.pc_redirect_target, V_NORMAL);
    end
  endtask

  // Model: a held redirect is either absent or carries the first target seen while stalled.
  task automatic test_random(input int n);
    logic            has_pend;
    logic [XLEN-1:0] pend;
    logic            cs, lu;
    logic [8:0]      exp_v;
    logic [XLEN-1:0] exp_t;
    int unsigned     m_stall, m_bub, m_flush;
    has_pend = 1'b0;
    pend     = '0;
    m_stall  = 0;
    m_bub    = 0;
    m_flush  = 0;
    @(negedge clk);
    rst = 1'b1;
    clear_in();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      rst                 = ($urandom_range(0, 59) == 0);
      bus.id_valid        = ($urandom_range(0, 3) != 0);
      bus.id_rs1_addr     = 5'($urandom_range(0, 3));
      bus.id_rs2_addr     = 5'($urandom_range(0, 3));
      bus.id_rs1_valid    = 1'($urandom_range(0, 1));
      bus.id_rs2_valid    = 1'($urandom_range(0, 1));
      bus.ex_valid        = ($urandom_range(0, 3) != 0);
      bus.ex_rd_addr      = 5'($urandom_range(0, 3));
      bus.ex_rd_valid     = ($urandom_range(0, 3) != 0);
      bus.ex_is_load      = 1'($urandom_range(0, 1));
      bus.icache_stall    = ($urandom_range(0, 5) == 0);
      bus.dcache_stall    = ($urandom_range(0, 4) == 0);
      bus.redirect        = ($urandom_range(0, 4) == 0);
      bus.redirect_target = $urandom;
      cs = bus.icache_stall | bus.dcache_stall;
      lu = bus.ex_valid && bus.ex_is_load && bus.ex_rd_valid && bus.ex_rd_addr != 0 && bus.id_valid &&
           ((bus.id_rs1_valid && bus.id_rs1_addr == bus.ex_rd_addr) ||
            (bus.id_rs2_valid && bus.id_rs2_addr == bus.ex_rd_addr));
      exp_t = '0;
      if (rst)                          exp_v = V_ZERO;
      else if (cs)                      exp_v = V_FREEZE;
      else if (bus.redirect || has_pend) begin
        exp_v = V_REDIR;
        exp_t = has_pend ? pend : bus.redirect_target;
      end
      else if (lu)                      exp_v = V_LU;
      else                              exp_v = V_NORMAL;
      #1;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rand_outputs[%0d]: got %b expected %b", i, obs, exp_v);
      end
      checks++;
      if (bus.pc_redirect_target !== exp_t) begin
        errors++;
        $display("FAIL rand_target[%0d]: got %h expected %h", i, bus.pc_redirect_target, exp_t);
      end
      @(posedge clk);
      if (rst) begin
        has_pend = 1'b0;
        pend     = '0;
        m_stall  = 0;
        m_bub    = 0;
        m_flush  = 0;
      end else begin
        if (exp_v == V_FREEZE) m_stall++;
        if (exp_v == V_LU)     m_bub++;
        if (exp_v == V_REDIR)  m_flush++;
        if (cs) begin
          if (!has_pend && bus.redirect) begin
            has_pend = 1'b1;
            pend     = bus.redirect_target;
          end
        end else begin
          has_pend = 1'b0;
        end
      end
      @(negedge clk);
    end
    rst = 1'b0;
    clear_in();
`ifdef HAZARD_PERF_CNT_EN
    #1;
    checks++;
    if (perf_stall_cycles !== m_stall || perf_bubbles !== m_bub || perf_flushes !== m_flush) begin
      errors++;
      $display("FAIL rand_counters: got %0d/%0d/%0d expected %0d/%0d/%0d",
               perf_stall_cycles, perf_bubbles, perf_flushes, m_stall, m_bub, m_flush);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    test_reset();
    test_load_use();
    test_load_use_neg();
    test_redirect_run();
    test_freeze_redirect();
    test_priority();
    test_same_cycle_release();
    test_reset_mid_freeze();
    test_random(600);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
